// File: rtl/gpu_pkg.sv
// Shared frame-buffer geometry, controller state encoding and the pixel-to-word address helper.
package gpu_pkg;

   localparam int FB_WIDTH         = 320;
   localparam int FB_HEIGHT        = 200;
   localparam int FB_WORDS_PER_ROW = 40;
   localparam int FB_WORDS         = 8000;
   localparam int FB_ADDR_W        = 13;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_RD,
      ST_RDW,
      ST_MOD,
      ST_WR_DONE
   } fb_state_t;

   // y*40 + x/8 built from shifts so no multiplier is needed
   function automatic logic [FB_ADDR_W-1:0] fb_word_addr(input logic [8:0] x, input logic [7:0] y);
      logic [FB_ADDR_W-1:0] yw;
      yw = FB_ADDR_W'(y);
      return (yw << 5) + (yw << 3) + FB_ADDR_W'(x[8:3]);
   endfunction

endpackage

// File: rtl/fb_ctrl_if.sv
// Pixel command handshake and scanout word port between the GPU and the frame-buffer controller.
interface fb_ctrl_if;
   import gpu_pkg::*;

   logic [8:0]           x_b;
   logic [7:0]           y_b;
   logic                 read_b;
   logic                 write_b;
   logic                 in_b;
   logic                 out_b;
   logic                 rdy_b;
   logic                 scan_req;
   logic [FB_ADDR_W-1:0] scan_addr;
   logic [7:0]           scan_data;
   logic                 scan_valid;

   modport master (
      output x_b, y_b, read_b, write_b, in_b, scan_req, scan_addr,
      input  out_b, rdy_b, scan_data, scan_valid
   );

   modport slave (
      input  x_b, y_b, read_b, write_b, in_b, scan_req, scan_addr,
      output out_b, rdy_b, scan_data, scan_valid
   );

endinterface

// File: rtl/fb_ram.sv
// Single-port synchronous frame-buffer RAM: address registered on enable, read data one cycle later.
module fb_ram import gpu_pkg::*; #(
   parameter int DEPTH = FB_WORDS,
   parameter int AW    = FB_ADDR_W
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] addr_q;

   always_ff @(posedge clk) begin
      if (en) begin
         addr_q <= addr;
         if (we) mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr_q];

endmodule

// File: rtl/fb_ctrl.sv
// Frame-buffer controller: pixel read/read-modify-write FSM, power-up clear, and a scanout
// port that always wins the single RAM port.
module fb_ctrl import gpu_pkg::*; #(
   parameter int WIDTH          = FB_WIDTH,
   parameter int HEIGHT         = FB_HEIGHT,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input logic      clk,
   input logic      rst_n,
   fb_ctrl_if.slave bus
);

   localparam logic [8:0]           X_LIM     = 9'(WIDTH);
   localparam logic [7:0]           Y_LIM     = 8'(HEIGHT);
   localparam logic [FB_ADDR_W-1:0] LAST_WORD = FB_ADDR_W'(FB_WORDS - 1);
   localparam logic [FB_ADDR_W-1:0] SCAN_LIM  = FB_ADDR_W'(FB_WORDS);
   localparam fb_state_t            RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

   fb_state_t            state, state_n;
   logic [8:0]           x_q;
   logic [7:0]           y_q;
   logic                 in_q, wr_q, oob_q, pend_q;
   logic [FB_ADDR_W-1:0] clr_addr;
   logic [7:0]           word_q;
   logic                 rdy_q, out_q;
   logic                 scan_q, scan_oob_q, scan_valid_q;
   logic [7:0]           scan_data_q;

   logic                 ram_en, ram_we;
   logic [FB_ADDR_W-1:0] ram_addr;
   logic [7:0]           ram_wdata, ram_rdata;

   logic                 strobe, port_free, scan_oob, req_oob, load_req;
   logic [FB_ADDR_W-1:0] word_addr;
   logic [7:0]           bit_mask, merged;

   assign strobe    = bus.read_b | bus.write_b;
   assign port_free = ~bus.scan_req;
   assign scan_oob  = bus.scan_addr >= SCAN_LIM;
   assign req_oob   = (bus.x_b >= X_LIM) || (bus.y_b >= Y_LIM);
   assign word_addr = fb_word_addr(x_q, y_q);
   assign bit_mask  = 8'b1 << x_q[2:0];
   assign merged    = (ram_rdata & ~bit_mask) | ({8{in_q}} & bit_mask);

   fb_ram #(.DEPTH(FB_WORDS), .AW(FB_ADDR_W)) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RST_STATE;
      else        state <= state_n;
   end

   // WR_DONE already presents rdy_b high, so it accepts a new strobe exactly like IDLE
   always_comb begin
      state_n   = state;
      ram_en    = bus.scan_req & ~scan_oob;
      ram_we    = 1'b0;
      ram_addr  = bus.scan_addr;
      ram_wdata = 8'h00;
      load_req  = 1'b0;
      case (state)
         ST_CLEAR: begin
            load_req = strobe & ~pend_q;
            if (port_free) begin
               ram_en   = 1'b1;
               ram_we   = 1'b1;
               ram_addr = clr_addr;
               if (clr_addr == LAST_WORD) state_n = (pend_q | strobe) ? ST_RD : ST_IDLE;
            end
         end
         ST_IDLE, ST_WR_DONE: begin
            load_req = strobe;
            state_n  = strobe ? ST_RD : ST_IDLE;
         end
         ST_RD: begin
            if (port_free) begin
               ram_en   = ~oob_q;
               ram_addr = word_addr;
               state_n  = ST_RDW;
            end
         end
         ST_RDW: state_n = wr_q ? ST_MOD : ST_IDLE;
         ST_MOD: begin
            if (port_free) begin
               ram_en    = ~oob_q;
               ram_we    = ~oob_q;
               ram_addr  = word_addr;
               ram_wdata = word_q;
               state_n   = ST_WR_DONE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q   <= '0;
         y_q   <= '0;
         in_q  <= 1'b0;
         wr_q  <= 1'b0;
         oob_q <= 1'b0;
      end else if (load_req) begin
         x_q   <= bus.x_b;
         y_q   <= bus.y_b;
         in_q  <= bus.in_b;
         wr_q  <= bus.write_b;
         oob_q <= req_oob;
      end
   end

   // A strobe seen during CLEAR is held in pend_q and launched straight from the last clear word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q    <= ~CLEAR_ON_RESET;
         out_q    <= 1'b0;
         pend_q   <= 1'b0;
         clr_addr <= '0;
         word_q   <= 8'h00;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (load_req) pend_q <= 1'b1;
               if (port_free) begin
                  if (clr_addr == LAST_WORD) begin
                     clr_addr <= '0;
                     pend_q   <= 1'b0;
                     rdy_q    <= ~(pend_q | strobe);
                  end else begin
                     clr_addr <= clr_addr + FB_ADDR_W'(1);
                  end
               end
            end
            ST_IDLE, ST_WR_DONE: if (strobe) rdy_q <= 1'b0;
            ST_RDW: begin
               if (wr_q) begin
                  word_q <= merged;
               end else begin
                  out_q <= oob_q ? 1'b0 : ram_rdata[x_q[2:0]];
                  rdy_q <= 1'b1;
               end
            end
            ST_MOD: if (port_free) rdy_q <= 1'b1;
            default: ;
         endcase
      end
   end

   // Two-stage scanout pipeline: address into the RAM, then RAM data into the output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_q       <= 1'b0;
         scan_oob_q   <= 1'b0;
         scan_valid_q <= 1'b0;
         scan_data_q  <= 8'h00;
      end else begin
         scan_q       <= bus.scan_req;
         scan_oob_q   <= scan_oob;
         scan_valid_q <= scan_q;
         if (scan_q) scan_data_q <= scan_oob_q ? 8'h00 : ram_rdata;
      end
   end

   assign bus.rdy_b      = rdy_q;
   assign bus.out_b      = out_q;
   assign bus.scan_data  = scan_data_q;
   assign bus.scan_valid = scan_valid_q;

endmodule

// File: tb/tb_fb_ctrl.sv
// Bench for fb_ctrl: pixel op vector table, scanout scoreboard and clear/reset/contention sequences.
module tb_fb_ctrl;
   import gpu_pkg::*;

   localparam logic [12:0] WORDS13 = 13'(FB_WORDS);

   typedef struct {
      logic [12:0] addr;
      logic [7:0]  data;
      int          cyc;
   } scan_exp_t;

   typedef struct {
      logic       wr;
      logic [8:0] x;
      logic [7:0] y;
      logic       din;
      int         lat;
      logic       dout;
   } vec_t;

   logic      clk = 1'b0;
   logic      rst_n;
   int        cyc = 0;
   int        errors = 0;
   int        checks = 0;
   int        valid_count = 0;
   logic [7:0] model [FB_WORDS];
   scan_exp_t exp_q [$];
   vec_t      vecs [$];

   fb_ctrl_if bus ();

   fb_ctrl #(.WIDTH(FB_WIDTH), .HEIGHT(FB_HEIGHT), .CLEAR_ON_RESET(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic void push_scan(input logic [12:0] addr);
      scan_exp_t e;
      e.addr = addr;
      e.data = (addr < WORDS13) ? model[addr] : 8'h00;
      e.cyc  = cyc;
      exp_q.push_back(e);
   endfunction

   task automatic drive_scan(input logic [12:0] addr);
      bus.scan_req  = 1'b1;
      bus.scan_addr = addr;
      push_scan(addr);
   endtask

   task automatic scan_word(input logic [12:0] addr);
      @(negedge clk);
      drive_scan(addr);
      @(negedge clk);
      bus.scan_req = 1'b0;
   endtask

   task automatic drain_scans();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      check_output("scan_drain_pending", exp_q.size(), 0);
   endtask

   task automatic wait_ready(input int bound, input int t_ref, output int cycles);
      cycles = -1;
      for (int i = 0; i < bound; i++) begin
         if (bus.rdy_b === 1'b1) begin
            cycles = cyc - t_ref;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic apply_stimulus(input logic wr, input logic [8:0] x, input logic [7:0] y, input logic din,
                                 output int lat, output logic dout);
      int t;
      @(negedge clk);
      bus.x_b     = x;
      bus.y_b     = y;
      bus.in_b    = din;
      bus.write_b = wr;
      bus.read_b  = ~wr;
      t = cyc;
      @(negedge clk);
      bus.read_b  = 1'b0;
      bus.write_b = 1'b0;
      wait_ready(100, t, lat);
      dout = bus.out_b;
   endtask

   // Scoreboard: every scan_valid pulse pops the oldest expected word and checks data and latency
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.scan_valid === 1'b1) begin
         valid_count++;
         if (exp_q.size() == 0) begin
            check_output("scan_unexpected_valid", 1, 0);
         end else begin
            scan_exp_t e;
            e = exp_q.pop_front();
            check_output($sformatf("scan_data_addr%0d", e.addr), bus.scan_data, e.data);
            check_output($sformatf("scan_latency_addr%0d", e.addr), cyc - e.cyc, 2);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lat;
      int          low;
      int          t0;
      int          vbase;
      int          idx;
      logic        dout;

      vecs.push_back('{1'b1, 9'd13,  8'd2,   1'b1, 4, 1'b0});
      for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 9'(8 + i), 8'd199, ~i[0], 4, 1'b0});
      vecs.push_back('{1'b1, 9'd320, 8'd5,   1'b1, 4, 1'b0});
      vecs.push_back('{1'b1, 9'd10,  8'd200, 1'b1, 4, 1'b0});
      vecs.push_back('{1'b0, 9'd14,  8'd199, 1'b0, 3, 1'b1});
      vecs.push_back('{1'b0, 9'd320, 8'd5,   1'b0, 3, 1'b0});
      vecs.push_back('{1'b0, 9'd12,  8'd2,   1'b0, 3, 1'b0});
      vecs.push_back('{1'b0, 9'd13,  8'd2,   1'b0, 3, 1'b1});
      vecs.push_back('{1'b0, 9'd9,   8'd199, 1'b0, 3, 1'b0});

      bus.x_b = '0; bus.y_b = '0; bus.read_b = 1'b0; bus.write_b = 1'b0; bus.in_b = 1'b0;
      bus.scan_req = 1'b0; bus.scan_addr = '0;
      foreach (model[i]) model[i] = 8'h00;

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset_rdy_b", bus.rdy_b, 0);
      check_output("reset_out_b", bus.out_b, 0);
      check_output("reset_scan_valid", bus.scan_valid, 0);
      check_output("reset_scan_data", bus.scan_data, 0);

      $display("[TB] power-up clear with two strobes issued mid-clear");
      rst_n = 1'b1;
      t0 = cyc;
      repeat (100) @(negedge clk);
      bus.x_b = 9'd0; bus.y_b = 8'd0; bus.in_b = 1'b1; bus.write_b = 1'b1;
      @(negedge clk);
      bus.write_b = 1'b0;
      check_output("clear_rdy_low", bus.rdy_b, 0);
      repeat (100) @(negedge clk);
      bus.x_b = 9'd1; bus.y_b = 8'd0; bus.in_b = 1'b1; bus.write_b = 1'b1;
      @(negedge clk);
      bus.write_b = 1'b0;
      wait_ready(9000, t0, low);
      check_output("clear_low_at_least_8000", int'(low >= 8000), 1);
      check_output("clear_low_at_most_8010", int'(low >= 0 && low <= 8010), 1);
      model[0] = 8'h01;
      scan_word(13'd0);
      scan_word(13'd3999);
      scan_word(13'd7999);
      drain_scans();

      $display("[TB] pixel vector table");
      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].wr, vecs[i].x, vecs[i].y, vecs[i].din, lat, dout);
         check_output($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         if (!vecs[i].wr) begin
            check_output($sformatf("vec%0d_out_b", i), int'(dout), int'(vecs[i].dout));
         end else if (vecs[i].x < 9'd320 && vecs[i].y < 8'd200) begin
            idx = int'(vecs[i].y) * 40 + int'(vecs[i].x) / 8;
            model[13'(idx)][vecs[i].x[2:0]] = vecs[i].din;
         end
      end

      $display("[TB] pixel read stalled by five scan requests");
      @(negedge clk);
      bus.x_b = 9'd13; bus.y_b = 8'd2; bus.read_b = 1'b1;
      t0 = cyc;
      @(negedge clk);
      bus.read_b = 1'b0;
      vbase = valid_count;
      for (int k = 0; k < 5; k++) begin
         drive_scan(13'(81 + k));
         @(negedge clk);
      end
      bus.scan_req = 1'b0;
      wait_ready(50, t0, lat);
      check_output("contended_read_latency", lat, 8);
      check_output("contended_read_out_b", bus.out_b, 1);
      drain_scans();
      check_output("contended_scan_pulses", valid_count - vbase, 5);

      $display("[TB] targeted scans");
      scan_word(13'd81);
      scan_word(13'd7961);
      scan_word(13'd7960);
      scan_word(13'd7962);
      scan_word(13'd240);
      scan_word(13'd8000);
      scan_word(13'd8191);
      drain_scans();

      $display("[TB] back-to-back scan of the whole buffer");
      vbase = valid_count;
      @(negedge clk);
      for (int a = 0; a < FB_WORDS; a++) begin
         drive_scan(13'(a));
         @(negedge clk);
      end
      bus.scan_req = 1'b0;
      drain_scans();
      check_output("full_scan_pulses", valid_count - vbase, FB_WORDS);

      $display("[TB] reset pulsed during a pixel write");
      @(negedge clk);
      bus.x_b = 9'd1; bus.y_b = 8'd0; bus.in_b = 1'b1; bus.write_b = 1'b1;
      @(negedge clk);
      bus.write_b = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_output("midop_reset_rdy_b", bus.rdy_b, 0);
      check_output("midop_reset_scan_valid", bus.scan_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      t0 = cyc;
      foreach (model[i]) model[i] = 8'h00;
      @(negedge clk);
      check_output("reclear_rdy_low", bus.rdy_b, 0);
      wait_ready(9000, t0, low);
      check_output("reclear_low_at_least_8000", int'(low >= 8000), 1);
      check_output("reclear_low_at_most_8010", int'(low >= 0 && low <= 8010), 1);
      scan_word(13'd0);
      scan_word(13'd81);
      scan_word(13'd7961);
      drain_scans();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
